// File: rtl/fifo_uart_tx_drain.sv
// fifo_uart_tx_drain
//   Read-side consumer for an 8-bit single-clock FIFO. Pops one byte whenever
//   data is available and fetching is enabled, then shifts it out as a UART 8N1
//   frame (start bit, 8 data bits LSB first, stop bit) on tx.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active-low
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  registered pop request, one-cycle pulse per byte
//   tx_enable   allows new fetches; only looked at when a fetch may begin
//   tx          serial output, idle high
//   busy        high in every state except IDLE
//   byte_done   one-cycle pulse after a frame's stop bit completes
//   bytes_sent  count of completed frames, wraps silently
module fifo_uart_tx_drain #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
    input  logic             tx_enable,
    output logic             tx,
    output logic             busy,
    output logic             byte_done,
    output logic [CNT_W-1:0] bytes_sent
);

    localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [CNT_W-1:0]  bytes_sent_q, bytes_sent_d;
    logic              tx_q, tx_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              can_fetch;
    logic              baud_last;

    always_comb begin
        can_fetch    = tx_enable && !fifo_empty;
        baud_last    = (baud_q == BAUD_LAST);
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        bytes_sent_d = bytes_sent_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (can_fetch) state_d = S_FETCH;
            end
            S_FETCH: begin
                baud_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // Read data is valid now, one cycle after the pop request.
                baud_d  = '0;
                shift_d = fifo_data;
                state_d = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d       = '0;
                    done_d       = 1'b1;
                    bytes_sent_d = bytes_sent_q + 1'b1;
                    state_d      = can_fetch ? S_FETCH : S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up cycle-for-cycle with the state they belong to.
        rd_en_d = (state_d == S_FETCH);
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            bytes_sent_q <= '0;
            tx_q         <= 1'b1;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            bytes_sent_q <= bytes_sent_d;
            tx_q         <= tx_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign byte_done  = done_q;
    assign bytes_sent = bytes_sent_q;

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
module tb_fifo_uart_tx_drain;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd_en;
    logic        tx_enable = 1'b0;
    logic        tx;
    logic        busy;
    logic        byte_done;
    logic [15:0] bytes_sent;

    int errors = 0;
    int checks = 0;

    // Simple FIFO model: pushes from the stimulus process, pops on rd_en.
    logic [7:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int viol_cnt = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    fifo_uart_tx_drain #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx_enable  (tx_enable),
        .tx         (tx),
        .busy       (busy),
        .byte_done  (byte_done),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (wr_ptr == rd_ptr) begin
                viol_cnt <= viol_cnt + 1;
            end else begin
                fifo_data <= mem[rd_ptr % 256];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    always @(negedge clk) if (byte_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 256] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Waits for the start bit (counting high cycles seen first), then checks
    // every cycle of the 10-bit frame. Returns at the negedge of the last stop cycle.
    task automatic expect_frame(input logic [7:0] b, input int drop_at, output int gap);
        logic [9:0] fr;
        bit found;
        fr = {1'b1, b, 1'b0};
        gap = 0;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1;
            else gap++;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_start byte=%02h: no start bit within 300 cycles", b);
            return;
        end
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (drop_at == i) tx_enable = 1'b0;
            checks++;
            if (tx !== fr[i / CPB]) begin
                errors++;
                $display("FAIL frame_bit byte=%02h cycle=%0d: tx=%b expected=%b", b, i, tx, fr[i / CPB]);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, busy, fifo_rd_en, byte_done} !== 4'b1000 || bytes_sent !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: tx/busy/rd/done=%b bytes_sent=%h expected 1000/0000",
                     {tx, busy, fifo_rd_en, byte_done}, bytes_sent);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_empty: busy=%b rd_en=%b expected 0/0", busy, fifo_rd_en);
        end
    endtask

    task automatic test_single;
        int gap, rd0, dn0;
        rd0 = rd_cnt; dn0 = done_cnt;
        push(8'hA5);
        tx_enable = 1'b1;
        expect_frame(8'hA5, -1, gap);
        checks++;
        if (gap != 2) begin
            errors++;
            $display("FAIL start_latency: high cycles=%0d expected 2", gap);
        end
        @(negedge clk);
        checks++;
        if (byte_done !== 1'b1 || bytes_sent !== 16'd1) begin
            errors++;
            $display("FAIL single_done: byte_done=%b bytes_sent=%0d expected 1/1", byte_done, bytes_sent);
        end
        @(negedge clk);
        checks++;
        if (byte_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after: byte_done=%b busy=%b expected 0/0", byte_done, busy);
        end
        checks++;
        if (rd_cnt - rd0 != 1 || done_cnt - dn0 != 1) begin
            errors++;
            $display("FAIL single_counts: pops=%0d done_pulses=%0d expected 1/1", rd_cnt - rd0, done_cnt - dn0);
        end
    endtask

    task automatic test_back_to_back;
        int gap, rd0;
        rd0 = rd_cnt;
        push(8'h00);
        push(8'hFF);
        expect_frame(8'h00, -1, gap);
        expect_frame(8'hFF, -1, gap);
        checks++;
        if (gap != 2) begin
            errors++;
            $display("FAIL b2b_gap: high cycles=%0d expected 2", gap);
        end
        @(negedge clk);
        // Two more frames on top of the single frame already sent.
        checks++;
        if (byte_done !== 1'b1 || bytes_sent !== 16'd3) begin
            errors++;
            $display("FAIL b2b_done: byte_done=%b bytes_sent=%0d expected 1/3", byte_done, bytes_sent);
        end
        checks++;
        if (rd_cnt - rd0 != 2) begin
            errors++;
            $display("FAIL b2b_pops: pops=%0d expected 2", rd_cnt - rd0);
        end
    endtask

    task automatic test_enable;
        int gap, rd0, bad;
        tx_enable = 1'b0;
        @(negedge clk);
        rd0 = rd_cnt;
        push(8'h5A);
        push(8'h3C);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL disabled_hold: bad cycles=%0d expected 0", bad);
        end
        tx_enable = 1'b1;
        // Drop enable during data bit 2 of the frame.
        expect_frame(8'h5A, 3 * CPB + 1, gap);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drop_enable_idle: bad cycles=%0d expected 0", bad);
        end
        checks++;
        if (rd_cnt - rd0 != 1 || bytes_sent !== 16'd4) begin
            errors++;
            $display("FAIL drop_enable_counts: pops=%0d bytes_sent=%0d expected 1/4", rd_cnt - rd0, bytes_sent);
        end
    endtask

    task automatic test_reset_midframe;
        int rd0, dn0, bad;
        bit found;
        rd0 = rd_cnt; dn0 = done_cnt;
        tx_enable = 1'b1;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1;
        end
        repeat (CPB + 1) @(negedge clk);
        // Now in data bit 0 of 0x3C, which is a 0.
        checks++;
        if (!found || tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: found=%0d tx=%b busy=%b expected 1/0/1", found, tx, busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({tx, busy, fifo_rd_en, byte_done} !== 4'b1000 || bytes_sent !== 16'h0) begin
            errors++;
            $display("FAIL midframe_reset: tx/busy/rd/done=%b bytes_sent=%h expected 1000/0000",
                     {tx, busy, fifo_rd_en, byte_done}, bytes_sent);
        end
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx !== 1'b1 || byte_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || done_cnt != dn0 || rd_cnt - rd0 != 1) begin
            errors++;
            $display("FAIL post_reset_idle: bad=%0d done_pulses=%0d pops=%0d expected 0/0/1",
                     bad, done_cnt - dn0, rd_cnt - rd0);
        end
    endtask

    task automatic test_wrap;
        int gap;
        @(negedge clk);
        force dut.bytes_sent_q = 16'hFFFF;
        @(negedge clk);
        release dut.bytes_sent_q;
        @(negedge clk);
        checks++;
        if (bytes_sent !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preset: bytes_sent=%h expected ffff", bytes_sent);
        end
        push(8'h81);
        expect_frame(8'h81, -1, gap);
        @(negedge clk);
        checks++;
        if (bytes_sent !== 16'h0000 || byte_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap: bytes_sent=%h byte_done=%b expected 0000/1", bytes_sent, byte_done);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_enable;
        test_reset_midframe;
        test_wrap;
        repeat (2) @(negedge clk);
        checks++;
        if (viol_cnt != 0) begin
            errors++;
            $display("FAIL rd_while_empty: count=%0d expected 0", viol_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
